// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcodes, funct3 codes, FSM states and access-legality helpers
// shared by the memory-access stage.
package mem_stage_pkg;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        return store ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                     : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW ||
                        f3 == F3_LBU || f3 == F3_LHU);
    endfunction

    // Low two funct3 bits encode access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-bus req/ack handshake between the memory stage (master)
// and the memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_load_ext.sv
// mem_stage_load_ext: selects the addressed byte/half of a load word and
// sign- or zero-extends it according to funct3.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        value = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
                funct3 == F3_LH  ? {{16{h[15]}}, h} :
                funct3 == F3_LBU ? {24'b0, b}       :
                funct3 == F3_LHU ? {16'b0, h}       : rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; runs one bus transaction per legal load/store,
// stalls upstream while waiting, and registers the MEM/WB result.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] c,
    input  logic [31:0] data2,
    input  logic [4:0]  rd,
    output logic        stall,
    mem_stage_if.master bus,
    output logic        out_valid,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        exc
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data2_q, data2_d;
    logic [4:0]  rd_q, rd_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_data_q, out_data_d;
    logic        exc_q, exc_d;

    logic        busy, is_load, is_store, is_mem, go;
    logic [3:0]  be;
    logic [31:0] wdata, ld_val;

    assign busy     = state_q == BUSY;
    assign is_load  = opcode == LOAD_OP;
    assign is_store = opcode == STORE_OP;
    assign is_mem   = is_load || is_store;
    assign go       = in_valid && is_mem && f3_legal(is_store, funct3) && !misaligned(funct3, c[1:0]);
    assign stall    = busy ? !bus.mem_ack : go;

    always_comb begin
        be    = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
                f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = f3_q[1:0] == 2'b00 ? {4{data2_q[7:0]}} :
                f3_q[1:0] == 2'b01 ? {2{data2_q[15:0]}} : data2_q;
    end

    // Bus outputs come only from registered state, so they are quiet in reset.
    assign bus.mem_req   = busy;
    assign bus.mem_we    = busy && we_q;
    assign bus.mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_be    = busy ? be : '0;
    assign bus.mem_wdata = busy ? wdata : '0;

    mem_stage_load_ext u_load_ext (
        .rdata  (bus.mem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .value  (ld_val)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        data2_d     = data2_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        exc_d       = 1'b0;
        if (busy) begin
            if (bus.mem_ack) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_rd_d    = we_q ? 5'd0 : rd_q;
                out_data_d  = we_q ? 32'd0 : ld_val;
            end
        end else if (in_valid) begin
            if (!is_mem) begin
                out_valid_d = 1'b1;
                out_rd_d    = rd;
                out_data_d  = c;
            end else if (!go) begin
                out_valid_d = 1'b1;
                out_rd_d    = 5'd0;
                out_data_d  = 32'd0;
                exc_d       = 1'b1;
            end else begin
                state_d = BUSY;
                we_d    = is_store;
                f3_d    = funct3;
                addr_d  = c;
                data2_d = data2;
                rd_d    = rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            data2_q     <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            data2_q     <= data2_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            exc_q       <= exc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_data  = out_data_q;
    assign exc       = exc_q;

endmodule
